// File: rtl/ddr3_wb_arbiter.sv
// rtl/ddr3_wb_arbiter.sv - round-robin Wishbone arbiter with in-order ack routing
// Shares the controller's pipelined Wishbone slave port among NUM_REQ requesters.
module ddr3_wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int AW         = 24,
  parameter int DW         = 512,
  parameter int SELW       = DW/8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    i_controller_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_cyc,
  input  logic [NUM_REQ-1:0]      i_req_stb,
  input  logic [NUM_REQ-1:0]      i_req_we,
  input  logic [NUM_REQ*AW-1:0]   i_req_addr,
  input  logic [NUM_REQ*DW-1:0]   i_req_data,
  input  logic [NUM_REQ*SELW-1:0] i_req_sel,
  output logic [NUM_REQ-1:0]      o_req_stall,
  output logic [NUM_REQ-1:0]      o_req_ack,
  output logic [DW-1:0]           o_req_data,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [AW-1:0]           o_wb_addr,
  output logic [DW-1:0]           o_wb_data,
  output logic [SELW-1:0]         o_wb_sel,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic [DW-1:0]           i_wb_data,
  output logic                    o_err_ack
);
  localparam int IDW = (NUM_REQ > 2) ? 2 : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_ABORT = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [IDW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                           out_valid_q, out_valid_d;
  logic [IDW-1:0]                 out_id_q, out_id_d;
  logic                           out_we_q, out_we_d;
  logic [AW-1:0]                  out_addr_q, out_addr_d;
  logic [DW-1:0]                  out_data_q, out_data_d;
  logic [SELW-1:0]                out_sel_q, out_sel_d;
  logic [FIFO_DEPTH-1:0][IDW-1:0] fid_q, fid_d;
  logic [FIFO_DEPTH-1:0]          live_q, live_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]                    count_q, count_d;
  logic                           wb_cyc_q, wb_cyc_d;
  logic [NUM_REQ-1:0]             req_ack_q, req_ack_d;
  logic [DW-1:0]                  req_data_q, req_data_d;
  logic                           err_q, err_d;

  logic [NUM_REQ-1:0] eligible, stall;
  logic               out_live, accept, pop, slot_free, can_grant, found, grant;
  logic               any_live, head_live;
  logic [IDW-1:0]     win, cand;
  logic [PW+1:0]      outstanding;
  logic [PW-1:0]      offs;

  always_comb begin
    eligible    = i_req_cyc & i_req_stb;
    // A held request whose owner dropped cyc is invisible downstream and never pushed.
    out_live    = out_valid_q && i_req_cyc[out_id_q];
    accept      = out_live && !i_wb_stall;
    pop         = i_wb_ack && (count_q != '0);
    outstanding = {1'b0, count_q} + (PW+2)'(out_live);
    slot_free   = !out_live || !i_wb_stall;
    can_grant   = !i_rst && (state_q == ST_RUN) && slot_free &&
                  ((outstanding - (PW+2)'(pop)) < (PW+2)'(FIFO_DEPTH));

    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant = can_grant && found;
    stall = '1;
    if (grant) stall[win] = 1'b0;

    out_valid_d = out_live && i_wb_stall;
    out_id_d    = out_id_q;
    out_we_d    = out_we_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_id_d    = win;
      out_we_d    = i_req_we[win];
      out_addr_d  = i_req_addr[win*AW +: AW];
      out_data_d  = i_req_data[win*DW +: DW];
      out_sel_d   = i_req_sel[win*SELW +: SELW];
      rr_ptr_d    = (win == IDW'(NUM_REQ-1)) ? '0 : win + IDW'(1);
    end

    fid_d  = fid_q;
    live_d = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) live_d[k] = live_q[k] && i_req_cyc[fid_q[k]];
    head_live = live_d[rd_ptr_q];

    any_live = 1'b0;
    offs     = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      offs = PW'(k) - rd_ptr_q;
      if (({1'b0, offs} < count_q) && live_q[k]) any_live = 1'b1;
    end

    req_ack_d  = '0;
    req_data_d = req_data_q;
    if (pop && head_live) begin
      req_ack_d[fid_q[rd_ptr_q]] = 1'b1;
      req_data_d                 = i_wb_data;
    end
    if (accept) begin
      fid_d[wr_ptr_q]  = out_id_q;
      live_d[wr_ptr_q] = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(accept) - (PW+1)'(pop);
    err_d    = err_q || (i_wb_ack && (count_q == '0));

    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if ((count_q != '0) && !any_live && !(|i_req_cyc)) state_d = ST_ABORT;
      end
      default: begin
        state_d  = ST_RUN;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        live_d   = '0;
      end
    endcase

    wb_cyc_d = (state_d == ST_RUN) && ((|i_req_cyc) || (count_d != '0) || out_valid_d);
  end

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      fid_q       <= '0;
      live_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wb_cyc_q    <= 1'b0;
      req_ack_q   <= '0;
      req_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_we_q    <= out_we_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      fid_q       <= fid_d;
      live_q      <= live_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wb_cyc_q    <= wb_cyc_d;
      req_ack_q   <= req_ack_d;
      req_data_q  <= req_data_d;
      err_q       <= err_d;
    end
  end

  assign o_req_stall = stall;
  assign o_req_ack   = req_ack_q;
  assign o_req_data  = req_data_q;
  assign o_wb_cyc    = wb_cyc_q;
  assign o_wb_stb    = out_live;
  assign o_wb_we     = out_we_q;
  assign o_wb_addr   = out_addr_q;
  assign o_wb_data   = out_data_q;
  assign o_wb_sel    = out_sel_q;
  assign o_err_ack   = err_q;
endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// tb/tb_ddr3_wb_arbiter.sv - self-checking bench for ddr3_wb_arbiter
module tb_ddr3_wb_arbiter;
  localparam int NR = 4, AW = 24, DW = 512, SELW = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     i_req_cyc, i_req_stb, i_req_we;
  logic [NR*AW-1:0]  i_req_addr;
  logic [NR*DW-1:0]  i_req_data;
  logic [NR*SELW-1:0] i_req_sel;
  logic [NR-1:0]     o_req_stall, o_req_ack;
  logic [DW-1:0]     o_req_data;
  logic              o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]     o_wb_addr;
  logic [DW-1:0]     o_wb_data;
  logic [SELW-1:0]   o_wb_sel;
  logic              i_wb_stall, i_wb_ack;
  logic [DW-1:0]     i_wb_data;
  logic              o_err_ack;

  ddr3_wb_arbiter dut (
    .i_controller_clk(clk), .i_rst(rst),
    .i_req_cyc(i_req_cyc), .i_req_stb(i_req_stb), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_sel(i_req_sel),
    .o_req_stall(o_req_stall), .o_req_ack(o_req_ack), .o_req_data(o_req_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_err_ack(o_err_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] stb;
    int            win;
  } vec_t;

  int            checks = 0, errors = 0;
  logic [NR-1:0] cyc_en, wr_en, last_gnt, exp_g;
  int            rem [NR];
  int            gcnt[NR];
  logic [AW-1:0] nxt_addr[NR];
  logic [AW-1:0] slave_q[$];
  logic [AW-1:0] acc_log[$];
  int            ack_id_log[$];
  logic [DW-1:0] ack_dat_log[$];
  logic          ack_en, force_ack, ackn, stb_after;
  logic [15:0]   stb_hist;
  vec_t          vecs[11];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16{8'hC3, a}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      i_req_cyc[i]                = cyc_en[i];
      i_req_stb[i]                = cyc_en[i] && (rem[i] > 0);
      i_req_we[i]                 = wr_en[i];
      i_req_addr[i*AW +: AW]      = nxt_addr[i];
      i_req_data[i*DW +: DW]      = pat(nxt_addr[i]);
      i_req_sel[i*SELW +: SELW]   = '1;
    end
    i_wb_ack  = force_ack || (ack_en && (slave_q.size() > 0));
    i_wb_data = (slave_q.size() > 0) ? pat(slave_q[0]) : '0;
  endtask

  task automatic tick();
    logic          acc;
    logic [AW-1:0] acc_a;
    #1;
    last_gnt = i_req_stb & i_req_cyc & ~o_req_stall;
    acc      = o_wb_stb && !i_wb_stall;
    acc_a    = o_wb_addr;
    ackn     = i_wb_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (last_gnt[i]) begin
        rem[i]--;
        nxt_addr[i]++;
        gcnt[i]++;
      end
    end
    if (ackn && (slave_q.size() > 0)) void'(slave_q.pop_front());
    if (acc) begin
      slave_q.push_back(acc_a);
      acc_log.push_back(acc_a);
    end
    for (int i = 0; i < NR; i++) begin
      if (o_req_ack[i]) begin
        ack_id_log.push_back(i);
        ack_dat_log.push_back(o_req_data);
      end
    end
    stb_after = o_wb_stb;
    drive();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cyc_en    = '0;
    wr_en     = '0;
    ack_en    = 1'b0;
    force_ack = 1'b0;
    i_wb_stall = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; gcnt[i] = 0; nxt_addr[i] = '0;
    end
    slave_q.delete(); acc_log.delete(); ack_id_log.delete(); ack_dat_log.delete();
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    vecs[0]  = '{4'b1111,  0};
    vecs[1]  = '{4'b1111,  1};
    vecs[2]  = '{4'b1001,  3};
    vecs[3]  = '{4'b0110,  1};
    vecs[4]  = '{4'b0011,  0};
    vecs[5]  = '{4'b0000, -1};
    vecs[6]  = '{4'b0001,  0};
    vecs[7]  = '{4'b1000,  3};
    vecs[8]  = '{4'b0100,  2};
    vecs[9]  = '{4'b0101,  0};
    vecs[10] = '{4'b0110,  1};

    // Reset state, with every requester asking to be granted.
    do_reset();
    rst = 1'b1;
    cyc_en = '1;
    for (int i = 0; i < NR; i++) rem[i] = 1;
    drive();
    @(posedge clk); #1;
    chk("rst_stall", o_req_stall, 4'b1111);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_ack", o_req_ack, 0);
    chk("rst_err", o_err_ack, 0);
    chk("rst_rdata", o_req_data, 0);
    chk("rst_addr", o_wb_addr, 0);

    // Round-robin table, cyc held on all requesters.
    do_reset();
    cyc_en = '1;
    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < NR; i++) begin
        rem[i]      = vecs[v].stb[i] ? 1 : 0;
        nxt_addr[i] = AW'(i*16 + v);
      end
      drive();
      tick();
      exp_g = (vecs[v].win < 0) ? '0 : (NR'(1) << vecs[v].win);
      chk($sformatf("rr_gnt_%0d", v), last_gnt, exp_g);
      chk($sformatf("rr_stb_%0d", v), stb_after, (vecs[v].win >= 0) ? 1 : 0);
      if (vecs[v].win >= 0) chk($sformatf("rr_addr_%0d", v), o_wb_addr, AW'(vecs[v].win*16 + v));
    end

    // Requester 0: 8 back-to-back writes, immediate acks.
    do_reset();
    cyc_en[0] = 1'b1; wr_en[0] = 1'b1; rem[0] = 8; ack_en = 1'b1;
    stb_hist = '0;
    drive();
    for (int t = 0; t < 12; t++) begin
      tick();
      stb_hist[t] = stb_after;
      if (t == 0) chk("c_we", o_wb_we, 1);
      chk($sformatf("c_ack_lat_%0d", t), o_req_ack, ackn ? 4'b0001 : 4'b0000);
    end
    chk("c_stb_run", stb_hist, 16'h00FF);
    chk("c_ack_cnt", ack_id_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < acc_log.size()) chk($sformatf("c_addr_%0d", k), acc_log[k], AW'(k));
      if (k < ack_id_log.size()) chk($sformatf("c_ack_id_%0d", k), ack_id_log[k], 0);
    end

    // All four requesters reading: ack order and routed data.
    do_reset();
    cyc_en = '1; ack_en = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 2; nxt_addr[i] = AW'(i*256 + 16);
    end
    drive();
    for (int t = 0; t < 16; t++) tick();
    chk("d_ack_cnt", ack_id_log.size(), 8);
    for (int k = 0; k < 8 && k < ack_id_log.size(); k++) begin
      chk($sformatf("d_ack_id_%0d", k), ack_id_log[k], k % 4);
      chk($sformatf("d_data_%0d", k), ack_dat_log[k], pat(AW'((k % 4)*256 + 16 + k / 4)));
    end

    // FIFO full: no acks, requester 1 streams.
    do_reset();
    cyc_en[1] = 1'b1; rem[1] = 40; nxt_addr[1] = 24'h100;
    drive();
    for (int t = 0; t < 25; t++) tick();
    chk("e_grants_full", gcnt[1], 16);
    #1;
    chk("e_stall_full", o_req_stall, 4'b1111);
    force_ack = 1'b1;
    drive();
    tick();
    chk("e_gnt_on_ack", last_gnt, 4'b0010);
    force_ack = 1'b0;
    drive();
    for (int t = 0; t < 3; t++) tick();
    chk("e_grants_after", gcnt[1], 17);
    chk("e_ack_cnt", ack_id_log.size(), 1);
    if (ack_id_log.size() > 0) begin
      chk("e_ack_id", ack_id_log[0], 1);
      chk("e_ack_data", ack_dat_log[0], pat(24'h100));
    end

    // Requester 2 aborts with reads interleaved with requester 0.
    do_reset();
    cyc_en[0] = 1'b1; cyc_en[2] = 1'b1;
    rem[0] = 3; rem[2] = 3; nxt_addr[0] = 24'h000; nxt_addr[2] = 24'h200;
    drive();
    for (int t = 0; t < 8; t++) tick();
    chk("f_gnt0", gcnt[0], 3);
    chk("f_gnt2", gcnt[2], 3);
    cyc_en[2] = 1'b0;
    drive();
    tick();
    ack_en = 1'b1;
    drive();
    for (int t = 0; t < 5; t++) tick();
    ack_en = 1'b0;
    drive();
    chk("f_ack_cnt", ack_id_log.size(), 3);
    for (int k = 0; k < 3 && k < ack_id_log.size(); k++) begin
      chk($sformatf("f_ack_id_%0d", k), ack_id_log[k], 0);
      chk($sformatf("f_data_%0d", k), ack_dat_log[k], pat(AW'(k)));
    end
    chk("f_cyc_before", o_wb_cyc, 1);
    cyc_en[0] = 1'b0;
    drive();
    tick();
    chk("f_cyc_abort", o_wb_cyc, 0);
    slave_q.delete(); ack_id_log.delete(); ack_dat_log.delete();
    cyc_en[1] = 1'b1; rem[1] = 1; nxt_addr[1] = 24'h300; ack_en = 1'b1;
    drive();
    tick();
    chk("f_no_gnt_abort", last_gnt, 4'b0000);
    chk("f_cyc_resume", o_wb_cyc, 1);
    tick();
    chk("f_gnt_resume", last_gnt, 4'b0010);
    for (int t = 0; t < 4; t++) tick();
    chk("f_post_ack_cnt", ack_id_log.size(), 1);
    if (ack_id_log.size() > 0) begin
      chk("f_post_ack_id", ack_id_log[0], 1);
      chk("f_post_data", ack_dat_log[0], pat(24'h300));
    end

    // Stray ack while idle sets the sticky error flag.
    do_reset();
    chk("g_err_before", o_err_ack, 0);
    force_ack = 1'b1;
    drive();
    tick();
    force_ack = 1'b0;
    drive();
    chk("g_err_set", o_err_ack, 1);
    for (int t = 0; t < 3; t++) tick();
    chk("g_err_sticky", o_err_ack, 1);
    chk("g_no_ack", ack_id_log.size(), 0);

    // Reset asserted in the middle of a read burst.
    cyc_en = '1; ack_en = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 4; nxt_addr[i] = AW'(i*256 + 1);
    end
    drive();
    for (int t = 0; t < 5; t++) tick();
    chk("h_busy_cyc", o_wb_cyc, 1);
    chk("h_busy_data", (o_req_data != '0) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    chk("h_stall", o_req_stall, 4'b1111);
    chk("h_cyc", o_wb_cyc, 0);
    chk("h_stb", o_wb_stb, 0);
    chk("h_we", o_wb_we, 0);
    chk("h_addr", o_wb_addr, 0);
    chk("h_wdata", o_wb_data, 0);
    chk("h_sel", o_wb_sel, 0);
    chk("h_ack", o_req_ack, 0);
    chk("h_rdata", o_req_data, 0);
    chk("h_err", o_err_ack, 0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
